piece_sequencer: RTL and testbench

- Sequences block-type selection for the Tetris field: generates pseudo-random block types and keeps a 2-entry queue (current piece + preview).
- Issues one piece per game-logic request over a req/ack handshake.
- spawn_type and preview_type drive the existing combinational block-type-to-shape lookup (3-bit type in, 16-bit shape out).
- Sits between the game-control FSM and the shape lookup.

---
 rtl/piece_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_piece_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_sequencer.sv
// piece_sequencer: free-running Galois LFSR feeding a two-slot piece queue
// (head + preview). Pieces are issued one at a time over spawn_req/spawn_ack.
// Optional build macro PIECE_SEQ_NO_REPEAT_EN: a candidate equal to the most
// recently accepted type is also rejected.
module piece_sequencer #(
  parameter logic [15:0] SEED      = 16'h0001,
  parameter int unsigned NUM_TYPES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        spawn_req,
  output logic        spawn_ack,
  output logic [2:0]  spawn_type,
  output logic [2:0]  preview_type,
  output logic        preview_valid,
  output logic        ready,
  output logic [15:0] pieces_issued
);

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned CNT_W  = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  // An all-zero seed would lock the LFSR, so it is replaced.
  localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [CNT_W-1:0]  CNT_MAX   = 16'hFFFF;
`ifdef PIECE_SEQ_NO_REPEAT_EN
  localparam logic [TYPE_W-1:0] TYPE_NONE = 3'd7;
`endif

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [TYPE_W-1:0]   head_q, head_d;
  logic                head_v_q, head_v_d;
  logic [TYPE_W-1:0]   prev_q, prev_d;
  logic                prev_v_q, prev_v_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic [TYPE_W-1:0]   spawn_type_q, spawn_type_d;
  logic [TYPE_W-1:0]   preview_type_q, preview_type_d;
  logic                preview_valid_q, preview_valid_d;
  logic                ready_q, ready_d;
`ifdef PIECE_SEQ_NO_REPEAT_EN
  logic [TYPE_W-1:0]   last_q, last_d;
`endif

  logic [TYPE_W-1:0]   cand;
  logic                cand_ok;

  // Candidate is the low bits of the LFSR before this cycle's step.
  always_comb begin
    cand = lfsr_q[TYPE_W-1:0];
`ifdef PIECE_SEQ_NO_REPEAT_EN
    cand_ok = (32'(cand) < NUM_TYPES) && (cand != last_q);
`else
    cand_ok = (32'(cand) < NUM_TYPES);
`endif
  end

  // Next-state: LFSR step, queue fill/shift, issue counter, restart clear.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    head_d   = head_q;
    head_v_d = head_v_q;
    prev_d   = prev_q;
    prev_v_d = prev_v_q;
    cnt_d    = cnt_q;
`ifdef PIECE_SEQ_NO_REPEAT_EN
    last_d   = last_q;
`endif

    case (state_q)
      ST_FILL: begin
        if (cand_ok) begin
          if (!head_v_q) begin
            head_d   = cand;
            head_v_d = 1'b1;
          end else begin
            prev_d   = cand;
            prev_v_d = 1'b1;
            state_d  = ST_READY;
          end
`ifdef PIECE_SEQ_NO_REPEAT_EN
          last_d = cand;
`endif
        end
      end
      ST_READY: begin
        if (spawn_req) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        head_d   = prev_q;
        head_v_d = prev_v_q;
        prev_v_d = 1'b0;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = ST_FILL;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    // New game: empty queue and counter; LFSR keeps running unseeded.
    if (restart) begin
      state_d  = ST_FILL;
      head_d   = '0;
      head_v_d = 1'b0;
      prev_d   = '0;
      prev_v_d = 1'b0;
      cnt_d    = '0;
`ifdef PIECE_SEQ_NO_REPEAT_EN
      last_d   = TYPE_NONE;
`endif
    end
  end

  // Registered outputs derived from the next state; during ISSUE the preview
  // shows the piece that becomes head after this issue.
  always_comb begin
    ack_d           = 1'b0;
    spawn_type_d    = spawn_type_q;
    preview_type_d  = head_d;
    preview_valid_d = head_v_d;
    ready_d         = (state_d == ST_READY);
    if (state_d == ST_ISSUE) begin
      ack_d           = 1'b1;
      spawn_type_d    = head_q;
      preview_type_d  = prev_q;
      preview_valid_d = prev_v_q;
    end
    if (restart) begin
      spawn_type_d = '0;
    end
  end

  // State and data registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_FILL;
      lfsr_q          <= SEED_EFF;
      head_q          <= '0;
      head_v_q        <= 1'b0;
      prev_q          <= '0;
      prev_v_q        <= 1'b0;
      cnt_q           <= '0;
      ack_q           <= 1'b0;
      spawn_type_q    <= '0;
      preview_type_q  <= '0;
      preview_valid_q <= 1'b0;
      ready_q         <= 1'b0;
`ifdef PIECE_SEQ_NO_REPEAT_EN
      last_q          <= TYPE_NONE;
`endif
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      head_q          <= head_d;
      head_v_q        <= head_v_d;
      prev_q          <= prev_d;
      prev_v_q        <= prev_v_d;
      cnt_q           <= cnt_d;
      ack_q           <= ack_d;
      spawn_type_q    <= spawn_type_d;
      preview_type_q  <= preview_type_d;
      preview_valid_q <= preview_valid_d;
      ready_q         <= ready_d;
`ifdef PIECE_SEQ_NO_REPEAT_EN
      last_q          <= last_d;
`endif
    end
  end

  // A reset or restart landing on the ISSUE cycle withdraws the ack at once.
  assign spawn_ack     = ack_q & ~reset & ~restart;
  assign spawn_type    = spawn_type_q;
  assign preview_type  = preview_type_q;
  assign preview_valid = preview_valid_q;
  assign ready         = ready_q;
  assign pieces_issued = cnt_q;

endmodule

// File: tb/tb_piece_sequencer.sv
// Testbench for piece_sequencer: directed reset-release table, restart/reset
// during ISSUE, counter saturation, then randomized traffic against a
// queue-level reference model. Two instances: SEED=1/5 types, SEED=0/3 types.
module tb_piece_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic restart = 1'b0;
  logic spawn_req = 1'b0;

  logic [1:0]       ack, pvalid, rdy;
  logic [1:0][2:0]  stype, ptype;
  logic [1:0][15:0] cnt;

  always #5 clk = ~clk;

  piece_sequencer #(.SEED(16'h0001), .NUM_TYPES(5)) dut0 (
    .clk(clk), .reset(reset), .restart(restart), .spawn_req(spawn_req),
    .spawn_ack(ack[0]), .spawn_type(stype[0]), .preview_type(ptype[0]),
    .preview_valid(pvalid[0]), .ready(rdy[0]), .pieces_issued(cnt[0]));

  piece_sequencer #(.SEED(16'h0000), .NUM_TYPES(3)) dut1 (
    .clk(clk), .reset(reset), .restart(restart), .spawn_req(spawn_req),
    .spawn_ack(ack[1]), .spawn_type(stype[1]), .preview_type(ptype[1]),
    .preview_valid(pvalid[1]), .ready(rdy[1]), .pieces_issued(cnt[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;
  int last_ack[2];
  int prev_t[2];
  int repeats = 0;

  // Reference model: a queue of accepted types plus a pending-issue flag.
  logic [15:0] m_lfsr[2];
  int          m_n[2];
  logic [2:0]  m_h[2];
  logic [2:0]  m_p[2];
  bit          m_pend[2];
  logic [2:0]  m_sp[2];
  logic [15:0] m_cnt[2];
`ifdef PIECE_SEQ_NO_REPEAT_EN
  logic [2:0]  m_last[2];
`endif

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int nt(input int i);
    return (i == 0) ? 5 : 3;
  endfunction

  function automatic logic [15:0] seed_eff(input int i);
    return (i == 0) ? 16'h0001 : 16'hACE1;
  endfunction

  task automatic model_step(input int i);
    logic [2:0] c;
    bit ok;
    if (reset) begin
      m_lfsr[i] = seed_eff(i);
      m_n[i] = 0; m_h[i] = 3'd0; m_p[i] = 3'd0; m_pend[i] = 1'b0;
      m_sp[i] = 3'd0; m_cnt[i] = 16'd0;
`ifdef PIECE_SEQ_NO_REPEAT_EN
      m_last[i] = 3'd7;
`endif
      return;
    end
    c = m_lfsr[i][2:0];
    m_lfsr[i] = lfsr_next(m_lfsr[i]);
    if (restart) begin
      m_n[i] = 0; m_h[i] = 3'd0; m_p[i] = 3'd0; m_pend[i] = 1'b0;
      m_sp[i] = 3'd0; m_cnt[i] = 16'd0;
`ifdef PIECE_SEQ_NO_REPEAT_EN
      m_last[i] = 3'd7;
`endif
    end else if (m_pend[i]) begin
      m_h[i] = m_p[i];
      m_n[i] = 1;
      m_pend[i] = 1'b0;
      if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
    end else if (m_n[i] == 2) begin
      if (spawn_req) begin
        m_pend[i] = 1'b1;
        m_sp[i] = m_h[i];
      end
    end else begin
      ok = int'(c) < nt(i);
`ifdef PIECE_SEQ_NO_REPEAT_EN
      ok = ok && (c != m_last[i]);
`endif
      if (ok) begin
        if (m_n[i] == 0) m_h[i] = c;
        else m_p[i] = c;
        m_n[i] = m_n[i] + 1;
`ifdef PIECE_SEQ_NO_REPEAT_EN
        m_last[i] = c;
`endif
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_cond(input string nm, input bit ok, input int act, input string req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required %s", nm, cyc, act, req);
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < 2; i++) begin
      logic [2:0] ept;
      ept = m_pend[i] ? m_p[i] : ((m_n[i] > 0) ? m_h[i] : 3'd0);
      chk($sformatf("ack%0d", i), 16'(ack[i]), 16'(m_pend[i] && !reset && !restart));
      chk($sformatf("spawn_type%0d", i), 16'(stype[i]), 16'(m_sp[i]));
      chk($sformatf("preview_type%0d", i), 16'(ptype[i]), 16'(ept));
      chk($sformatf("preview_valid%0d", i), 16'(pvalid[i]), 16'(m_n[i] > 0));
      chk($sformatf("ready%0d", i), 16'(rdy[i]), 16'((m_n[i] == 2) && !m_pend[i]));
      chk($sformatf("pieces%0d", i), cnt[i], m_cnt[i]);
    end
  endtask

  // Drive inputs, let them settle, compare against the model, track acks.
  task automatic apply(input bit r, input bit rs, input bit rq);
    reset = r; restart = rs; spawn_req = rq;
    #1;
    if (armed) compare_model();
    for (int i = 0; i < 2; i++) begin
      if (ack[i]) begin
        chk_cond($sformatf("ack_spacing%0d", i), (cyc - last_ack[i]) >= 3, cyc - last_ack[i], ">=3");
        chk_cond($sformatf("type_range%0d", i), int'(stype[i]) < nt(i), int'(stype[i]), "< NUM_TYPES");
        if (int'(stype[i]) == prev_t[i]) repeats++;
        prev_t[i] = int'(stype[i]);
        last_ack[i] = cyc;
      end
      if (r || rs) prev_t[i] = 7;
    end
  endtask

  task automatic adv();
    @(negedge clk);
    cyc++;
  endtask

  task automatic step(input bit r, input bit rs, input bit rq);
    apply(r, rs, rq);
    adv();
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (!rdy[i] && n < 200) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk_cond($sformatf("wait_ready%0d", i), rdy[i] == 1'b1, n, "ready within 200 cycles");
  endtask

  typedef struct packed {
    bit          rst;
    bit          rs;
    bit          rq;
    logic        ack;
    logic [2:0]  typ;
    logic [2:0]  pt;
    logic        pv;
    logic        rdy;
    logic [15:0] cnt;
    logic [15:0] lfsr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // Reset-release sequence for SEED=1, NUM_TYPES=5: types 1 then 0 fill the
    // queue, first issue is type 1, refill accepts 0 from lfsr 16'h1680.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0, 16'h0001};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 16'd0, 16'hB400};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 1'b1, 1'b1, 16'd0, 16'h5A00};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 16'd0, 16'h2D00};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 1'b1, 1'b0, 16'd1, 16'h1680};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 1'b1, 1'b1, 16'd1, 16'h0B40};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 16'd1, 16'h05A0};
    for (int i = 0; i < 2; i++) begin
      last_ack[i] = -100;
      prev_t[i] = 7;
    end

    @(negedge clk);
    @(negedge clk);
    armed = 1'b1;
    chk("seed0_replaced", dut1.lfsr_q, 16'hACE1);

    for (int k = 0; k < 7; k++) begin
      apply(tbl[k].rst, tbl[k].rs, tbl[k].rq);
      chk($sformatf("tbl%0d_ack", k), 16'(ack[0]), 16'(tbl[k].ack));
      chk($sformatf("tbl%0d_type", k), 16'(stype[0]), 16'(tbl[k].typ));
      chk($sformatf("tbl%0d_ptype", k), 16'(ptype[0]), 16'(tbl[k].pt));
      chk($sformatf("tbl%0d_pvalid", k), 16'(pvalid[0]), 16'(tbl[k].pv));
      chk($sformatf("tbl%0d_ready", k), 16'(rdy[0]), 16'(tbl[k].rdy));
      chk($sformatf("tbl%0d_pieces", k), cnt[0], tbl[k].cnt);
      chk($sformatf("tbl%0d_lfsr", k), dut0.lfsr_q, tbl[k].lfsr);
      adv();
    end

    // Restart on the ISSUE cycle: ack withdrawn, queue and count cleared.
    wait_ready(0);
    step(1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0);
    chk("restart_issue_ack", 16'(ack[0]), 16'd0);
    adv();
    chk("restart_pieces", cnt[0], 16'd0);
    chk("restart_pvalid", 16'(pvalid[0]), 16'd0);
    chk("restart_ready", 16'(rdy[0]), 16'd0);
    chk("restart_no_reseed", dut0.lfsr_q, m_lfsr[0]);

    // Reset on the ISSUE cycle: ack withdrawn, LFSR reseeded.
    wait_ready(0);
    step(1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b0);
    chk("reset_issue_ack", 16'(ack[0]), 16'd0);
    adv();
    chk("reset_lfsr0", dut0.lfsr_q, 16'h0001);
    chk("reset_lfsr1", dut1.lfsr_q, 16'hACE1);
    chk("reset_pieces", cnt[0], 16'd0);

    // Saturation: preload the counter near its ceiling, then issue three.
    wait_ready(0);
    force dut0.cnt_q = 16'hFFFE;
    m_cnt[0] = 16'hFFFE;
    step(1'b0, 1'b0, 1'b0);
    release dut0.cnt_q;
    step(1'b0, 1'b0, 1'b0);
    chk("sat_preload", cnt[0], 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      wait_ready(0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("sat_issue%0d", k), cnt[0], 16'hFFFF);
    end

    // Random request/restart traffic.
    for (int k = 0; k < 600; k++) begin
      step(1'b0, $urandom_range(99) == 0, $urandom_range(9) < 7);
    end

    // Requester holds spawn_req continuously.
    repeat (2) step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 1000; k++) begin
      step(1'b0, 1'b0, 1'b1);
    end

`ifdef PIECE_SEQ_NO_REPEAT_EN
    chk_cond("no_consecutive_repeat", repeats == 0, repeats, "0");
`else
    chk_cond("consecutive_repeat_seen", repeats > 0, repeats, ">0");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
